// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product stream engine: FSM encodings and
// width helpers used by the top and the adder tree.
package dotp_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Width of the registered adder-tree sum for a given operand width and lane count.
   function automatic int tree_sum_width(input int din, input int deg);
      return 2 * din + clog2(deg);
   endfunction

endpackage

// File: rtl/dotp_adder_tree.sv
// Stage S2: reduces Para_Deg lane products to one registered sum, carrying a
// valid bit alongside the data.
module dotp_adder_tree
   import dotp_pkg::*;
#(
   parameter int Para_Deg = 4,
   parameter int Prod_W   = 16,
   parameter int Sum_W    = 18
) (
   input  logic                       clk,
   input  logic                       Comp_reset,
   input  logic                       prod_valid,
   input  logic [Para_Deg*Prod_W-1:0] prod,
   output logic                       sum_valid,
   output logic [Sum_W-1:0]           sum
);

   logic [Sum_W-1:0] node [2*Para_Deg-1];
   logic [Sum_W-1:0] tree_sum;

   // Heap-ordered binary tree: leaves at the tail, node i sums children 2i+1, 2i+2.
   always_comb begin
      for (int i = 0; i < 2*Para_Deg-1; i++) node[i] = '0;
      for (int i = 0; i < Para_Deg; i++)
         node[Para_Deg-1+i] = Sum_W'(prod[i*Prod_W +: Prod_W]);
      for (int i = Para_Deg-2; i >= 0; i--)
         node[i] = node[2*i+1] + node[2*i+2];
      tree_sum = node[0];
   end

   always_ff @(posedge clk) begin
      if (Comp_reset) begin
         sum_valid <= 1'b0;
         sum       <= '0;
      end else begin
         sum_valid <= prod_valid;
         if (prod_valid) sum <= tree_sum;
      end
   end

endmodule

// File: rtl/dotp_stream_engine.sv
// Streaming dot-product engine: lane multipliers (S1), adder tree (S2) and
// accumulator (S3) behind a job FSM. Define DOTP_SATURATE_EN to clamp instead of wrap.
//
// state | meaning
// IDLE  | waiting for start; job parameters captured on start
// LOAD  | accepting beats until the beat counter reaches terminal count
// DRAIN | no new beats; waiting for the last beat to leave S3
// DONE  | result presented until the sink accepts it
module dotp_stream_engine
   import dotp_pkg::*;
#(
   parameter int Para_Deg       = 4,
   parameter int Data_Width_In  = 8,
   parameter int Data_Width_Out = 24,
   parameter int Beat_Cnt_Width = 8
) (
   input  logic                              clk,
   input  logic                              Comp_reset,
   input  logic                              start,
   input  logic [Beat_Cnt_Width-1:0]         beats,
   input  logic                              load_old,
   input  logic [Data_Width_Out-1:0]         acc_init,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [Para_Deg*Data_Width_In-1:0] a_data,
   input  logic [Para_Deg*Data_Width_In-1:0] b_data,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [Data_Width_Out-1:0]         result,
   output logic [1:0]                        state
);

   localparam int Prod_W = 2 * Data_Width_In;
   localparam int Tree_W = tree_sum_width(Data_Width_In, Para_Deg);

   logic [Beat_Cnt_Width-1:0]  remaining;
   logic [Data_Width_Out-1:0]  acc;
   logic [Data_Width_Out-1:0]  acc_upd;
   logic [Para_Deg*Prod_W-1:0] s1_prod;
   logic                       s1_valid;
   logic [Tree_W-1:0]          s2_sum;
   logic                       s2_valid;
   logic                       s3_valid;
   logic                       accept;
   logic                       last_beat;

   assign in_ready  = (state == LOAD);
   assign res_valid = (state == DONE);
   assign result    = acc;
   assign accept    = in_valid & in_ready;
   assign last_beat = (remaining == Beat_Cnt_Width'(1));

   always_ff @(posedge clk) begin
      if (Comp_reset) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            for (int i = 0; i < Para_Deg; i++)
               s1_prod[i*Prod_W +: Prod_W] <=
                  Prod_W'(a_data[i*Data_Width_In +: Data_Width_In]) *
                  Prod_W'(b_data[i*Data_Width_In +: Data_Width_In]);
         end
      end
   end

   dotp_adder_tree #(
      .Para_Deg (Para_Deg),
      .Prod_W   (Prod_W),
      .Sum_W    (Tree_W)
   ) u_tree (
      .clk        (clk),
      .Comp_reset (Comp_reset),
      .prod_valid (s1_valid),
      .prod       (s1_prod),
      .sum_valid  (s2_valid),
      .sum        (s2_sum)
   );

`ifdef DOTP_SATURATE_EN
   logic [Data_Width_Out:0] acc_wide;

   // Once clamped at all-ones, any further non-zero term carries again, so the clamp is sticky.
   always_comb begin
      acc_wide = {1'b0, acc} + {1'b0, Data_Width_Out'(s2_sum)};
      acc_upd  = acc_wide[Data_Width_Out] ? '1 : acc_wide[Data_Width_Out-1:0];
   end
`else
   always_comb begin
      acc_upd = acc + Data_Width_Out'(s2_sum);
   end
`endif

   always_ff @(posedge clk) begin
      if (Comp_reset) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         s3_valid  <= 1'b0;
      end else begin
         s3_valid <= s2_valid;
         if (s2_valid) acc <= acc_upd;
         case (state)
            IDLE: begin
               if (start) begin
                  acc       <= load_old ? acc_init : '0;
                  remaining <= beats;
                  state     <= (beats == '0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  remaining <= remaining - Beat_Cnt_Width'(1);
                  if (last_beat) state <= DRAIN;
               end
            end
            DRAIN: begin
               // No beats enter in DRAIN, so an empty S1/S2 with S3 just written means the last beat landed.
               if (s3_valid && !s2_valid && !s1_valid) state <= DONE;
            end
            DONE: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dotp_stream_engine.sv
// Self-checking bench for dotp_stream_engine: directed jobs plus randomized
// jobs, checked against a job-level arithmetic model by a per-cycle monitor.
module tb_dotp_stream_engine;

   localparam int P  = 4;
   localparam int W  = 8;
   localparam int WO = 24;
   localparam int BW = 8;
   localparam longint MAXV = 64'd16777215;

   logic            clk = 1'b0;
   logic            Comp_reset;
   logic            start;
   logic [BW-1:0]   beats;
   logic            load_old;
   logic [WO-1:0]   acc_init;
   logic            in_valid;
   logic            in_ready;
   logic [P*W-1:0]  a_data;
   logic [P*W-1:0]  b_data;
   logic            res_valid;
   logic            res_ready;
   logic [WO-1:0]   result;
   logic [1:0]      state;

   always #5 clk = ~clk;

   dotp_stream_engine #(
      .Para_Deg       (P),
      .Data_Width_In  (W),
      .Data_Width_Out (WO),
      .Beat_Cnt_Width (BW)
   ) dut (
      .clk        (clk),
      .Comp_reset (Comp_reset),
      .start      (start),
      .beats      (beats),
      .load_old   (load_old),
      .acc_init   (acc_init),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_data     (a_data),
      .b_data     (b_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .result     (result),
      .state      (state)
   );

   typedef struct {
      logic [WO-1:0] exp;
      int            nb;
      longint        start_edge;
   } job_t;

   int          total = 0;
   int          bad   = 0;
   longint      ecount = 0;
   logic [31:0] a_mem [256];
   logic [31:0] b_mem [256];
   job_t        job_q [$];
   int          accepts = 0;
   longint      due = 0;
   bit          prev_valid = 1'b0;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
      end
   endtask

   // Job-level model: preload plus the full dot product, then wrap or clamp.
   function automatic logic [WO-1:0] model(input int nb, input bit lo, input logic [WO-1:0] ai);
      longint e;
      logic [31:0] av, bv;
      e = lo ? longint'(ai) : 0;
      for (int b = 0; b < nb; b++) begin
         av = a_mem[b];
         bv = b_mem[b];
         for (int l = 0; l < P; l++)
            e += longint'(av[l*W +: W]) * longint'(bv[l*W +: W]);
      end
`ifdef DOTP_SATURATE_EN
      if (e > MAXV) e = MAXV;
`else
      e = e % (MAXV + 1);
`endif
      return e[WO-1:0];
   endfunction

   always @(negedge clk) begin
      if (Comp_reset) begin
         job_q.delete();
         accepts    = 0;
         prev_valid = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            bit ok;
            ok = (job_q.size() > 0) && (accepts < job_q[0].nb);
            check("accept_allowed", ok, 1);
            if (ok) begin
               accepts++;
               if (accepts == job_q[0].nb) due = ecount + 4;
            end
         end
         if (res_valid) begin
            check("res_has_job", job_q.size() > 0, 1);
            if (job_q.size() > 0) begin
               if (!prev_valid) begin
                  if (job_q[0].nb == 0) due = job_q[0].start_edge;
                  check("res_latency", ecount, due);
               end
               check("result", result, job_q[0].exp);
               check("in_ready_in_done", in_ready, 0);
               check("state_done", state, 3);
               if (res_ready) begin
                  void'(job_q.pop_front());
                  accepts = 0;
               end
            end
         end
         prev_valid = res_valid;
      end
   end

   task automatic send_start(input int nb, input bit lo, input logic [WO-1:0] ai);
      job_t j;
      @(posedge clk); #1;
      start    = 1'b1;
      beats    = BW'(nb);
      load_old = lo;
      acc_init = ai;
      j.exp        = model(nb, lo, ai);
      j.nb         = nb;
      j.start_edge = ecount + 1;
      job_q.push_back(j);
      @(posedge clk); #1;
      start    = 1'b0;
      beats    = BW'($urandom);
      load_old = 1'($urandom);
      acc_init = WO'($urandom);
   endtask

   task automatic send_beat(input int idx, input int gap);
      bit r;
      int n;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         a_data   = $urandom;
         b_data   = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a_data   = a_mem[idx];
      b_data   = b_mem[idx];
      n = 0;
      r = 1'b0;
      do begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!r && n < 1000);
      check("beat_accepted", r, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input int rdy_delay, input bit poke, output logic [WO-1:0] got);
      bit v;
      int n;
      res_ready = 1'b0;
      v = 1'b0;
      n = 0;
      while (!v && n < 2000) begin
         @(negedge clk);
         v = res_valid;
         if (!v) begin
            @(posedge clk); #1;
         end
         n++;
      end
      check("res_valid_seen", v, 1);
      got = result;
      for (int i = 0; i < rdy_delay; i++) begin
         @(posedge clk); #1;
         start = poke && (i == 0);
         if (start) beats = 8'd5;
         if (poke && i == 1) begin
            check("start_in_done_ignored", state, 3);
            check("done_result_stable", result, got);
         end
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      start     = poke;
      @(posedge clk); #1;
      res_ready = 1'b0;
      start     = 1'b0;
      check("idle_after_done", state, 0);
      check("res_valid_drop", res_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WO-1:0] got;
      Comp_reset = 1'b1;
      start      = 1'b0;
      beats      = '0;
      load_old   = 1'b0;
      acc_init   = '0;
      in_valid   = 1'b0;
      a_data     = '0;
      b_data     = '0;
      res_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      Comp_reset = 1'b0;
      check("rst_state", state, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_result", result, 0);

      // Test 1: two beats, continuous valid.
      a_mem[0] = 32'h04030201; b_mem[0] = 32'h01010101;
      a_mem[1] = 32'h08070605; b_mem[1] = 32'h01010101;
      send_start(2, 1'b0, '0);
      check("t1_state_load", state, 1);
      send_beat(0, 0);
      send_beat(1, 0);
      check("t1_state_drain", state, 2);
      check("t1_in_ready_drain", in_ready, 0);
      wait_result(0, 1'b0, got);
      check("t1_result", got, 36);

      // Test 2: preload with old value.
      a_mem[0] = 32'h02020202; b_mem[0] = 32'h03030303;
      send_start(1, 1'b1, 24'd100);
      send_beat(0, 0);
      wait_result(0, 1'b0, got);
      check("t2_result", got, 124);

      // Test 3: gaps between beats, back-pressured result, start pokes in DONE.
      a_mem[0] = 32'h04030201; b_mem[0] = 32'h01010101;
      a_mem[1] = 32'h08070605; b_mem[1] = 32'h01010101;
      a_mem[2] = 32'h01010101; b_mem[2] = 32'h01010101;
      send_start(3, 1'b0, '0);
      send_beat(0, 0);
      send_beat(1, 4);
      send_beat(2, 4);
      wait_result(5, 1'b1, got);
      check("t3_result", got, 40);

      // Test 4: zero-length job with valid held high.
      send_start(0, 1'b1, 24'd7);
      in_valid = 1'b1;
      a_data   = $urandom;
      b_data   = $urandom;
      wait_result(0, 1'b0, got);
      in_valid = 1'b0;
      check("t4_result", got, 7);

      // Test 5: maximum length, maximum operands.
      for (int i = 0; i < 255; i++) begin
         a_mem[i] = 32'hFFFFFFFF;
         b_mem[i] = 32'hFFFFFFFF;
      end
      send_start(255, 1'b0, '0);
      for (int i = 0; i < 255; i++) send_beat(i, 0);
      wait_result(0, 1'b0, got);
`ifdef DOTP_SATURATE_EN
      check("t5_result_sat", got, 16777215);
`else
      check("t5_result_wrap", got, 15993852);
`endif

      // Test 6: reset mid-LOAD, then a fresh job.
      a_mem[0] = 32'h04030201; b_mem[0] = 32'h01010101;
      a_mem[1] = 32'h08070605; b_mem[1] = 32'h01010101;
      a_mem[2] = 32'h11111111; b_mem[2] = 32'h22222222;
      a_mem[3] = 32'h33333333; b_mem[3] = 32'h44444444;
      send_start(4, 1'b1, 24'd55);
      send_beat(0, 0);
      send_beat(1, 0);
      Comp_reset = 1'b1;
      @(posedge clk); #1;
      Comp_reset = 1'b0;
      check("t6_state", state, 0);
      check("t6_in_ready", in_ready, 0);
      check("t6_res_valid", res_valid, 0);
      check("t6_result", result, 0);
      send_start(2, 1'b0, '0);
      send_beat(0, 0);
      send_beat(1, 0);
      wait_result(0, 1'b0, got);
      check("t6_fresh_result", got, 36);

      // Randomized jobs.
      for (int j = 0; j < 25; j++) begin
         int nb;
         bit lo;
         logic [WO-1:0] ai;
         nb = $urandom_range(0, 12);
         lo = 1'($urandom);
         ai = WO'($urandom);
         for (int i = 0; i < nb; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
         end
         send_start(nb, lo, ai);
         for (int i = 0; i < nb; i++) send_beat(i, $urandom_range(0, 3));
         wait_result($urandom_range(0, 3), 1'($urandom), got);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", job_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
